// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the Block Invaders game-flow controller and its
// consumers (renderer, ship and position generators).
package game_sequencer_pkg;

  // Game phase encoding; every block that decodes state uses this type.
  typedef enum logic [2:0] {
    ATTRACT   = 3'd0,
    PLAY      = 3'd1,
    RESPAWN   = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SCORE_W = 14;
  localparam int unsigned LEVEL_W = 3;
  localparam int unsigned CNT_W   = 8;

  // Saturating score accumulate; one extra bit catches the overflow.
  function automatic logic [SCORE_W-1:0] score_add(
    input logic [SCORE_W-1:0] cur,
    input logic [SCORE_W-1:0] inc,
    input logic [SCORE_W-1:0] max
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame timing: synchronises the active-low vsync, emits a one-clock
// frame_tick on each falling edge and counts ticks in a saturating counter
// that the sequencer clears on every phase change.
module frame_timer
  import game_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync,
  input  logic             clear,
  output logic             frame_tick,
  output logic [CNT_W-1:0] count
);

  logic sync_new;
  logic sync_old;
  logic sync_prev;

  // Two-flop synchroniser plus one history flop; the tick is registered,
  // giving three clocks from the vsync fall to frame_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_new   <= 1'b1;
      sync_old   <= 1'b1;
      sync_prev  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      sync_new   <= vsync;
      sync_old   <= sync_new;
      sync_prev  <= sync_old;
      frame_tick <= sync_prev & ~sync_old;
    end
  end

  // Saturating frame counter; clear wins over a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (frame_tick && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Block Invaders game-flow controller: attract / play / respawn / level-up /
// game-over sequencing, with lives, score and level bookkeeping.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned RESPAWN_FRAMES  = 120,
  parameter int unsigned LEVELUP_FRAMES  = 90,
  parameter int unsigned GAMEOVER_FRAMES = 180,
  parameter int unsigned BLINK_FRAMES    = 8,
  parameter int unsigned SCORE_PER_HIT   = 10,
  parameter int unsigned SCORE_MAX       = 9999,
  parameter int unsigned LEVEL_MAX       = 7
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  input  logic               vsync,
  input  logic               start,
  input  logic               ship_shot,
  input  logic               laser_shot,
  input  logic               wave_clear,
  output logic               frame_tick,
  output logic [STATE_W-1:0] state,
  output logic               play_en,
  output logic               blink,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [CNT_W-1:0]   RESPAWN_CNT  = CNT_W'(RESPAWN_FRAMES);
  localparam logic [CNT_W-1:0]   LEVELUP_CNT  = CNT_W'(LEVELUP_FRAMES);
  localparam logic [CNT_W-1:0]   GAMEOVER_CNT = CNT_W'(GAMEOVER_FRAMES);
  localparam logic [CNT_W:0]     BLINK_DIV    = (CNT_W+1)'(BLINK_FRAMES);
  localparam logic [1:0]         LIVES_LOAD   = 2'(LIVES_INIT);
  localparam logic [SCORE_W-1:0] SCORE_INC    = SCORE_W'(SCORE_PER_HIT);
  localparam logic [SCORE_W-1:0] SCORE_TOP    = SCORE_W'(SCORE_MAX);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP    = LEVEL_W'(LEVEL_MAX);

  state_t           state_q;
  state_t           state_next;
  logic             state_change;
  logic             arm;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_p1;
  logic             blink_hit;

  assign state = state_q;

  // The counter must clear on the very edge the phase changes, otherwise a
  // stale count from the previous phase could end the new phase at once, so
  // the next state is resolved combinationally and its change drives clear.
  assign state_change = (state_next != state_q);

  frame_timer u_frame_timer (
    .clk        (clk_100MHz),
    .rst        (reset),
    .vsync      (vsync),
    .clear      (state_change),
    .frame_tick (frame_tick),
    .count      (count)
  );

  // Blink toggles on the tick that brings the count to a multiple of the
  // half-period.
  assign count_p1  = {1'b0, count} + (CNT_W+1)'(1);
  assign blink_hit = frame_tick && ((count_p1 % BLINK_DIV) == '0);

  // Next-phase decision; ship_shot outranks wave_clear in PLAY.
  always_comb begin
    state_next = state_q;
    case (state_q)
      ATTRACT: begin
        if (start && arm) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (ship_shot) begin
          state_next = (lives <= 2'd1) ? GAME_OVER : RESPAWN;
        end else if (wave_clear) begin
          state_next = LEVEL_UP;
        end
      end
      RESPAWN: begin
        if (count >= RESPAWN_CNT) begin
          state_next = PLAY;
        end
      end
      LEVEL_UP: begin
        if (count >= LEVELUP_CNT) begin
          state_next = PLAY;
        end
      end
      GAME_OVER: begin
        if (count >= GAMEOVER_CNT) begin
          state_next = ATTRACT;
        end
      end
      default: state_next = ATTRACT;
    endcase
  end

  // Phase register with registered outputs, lives, score and level.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= ATTRACT;
      play_en <= 1'b0;
      blink   <= 1'b1;
      lives   <= '0;
      score   <= '0;
      level   <= '0;
      arm     <= 1'b0;
    end else begin
      state_q <= state_next;
      play_en <= (state_next == PLAY);

      // Arm only after start has been seen low in ATTRACT, so a held
      // button cannot restart the game.
      if ((state_q == ATTRACT) && (state_next == ATTRACT)) begin
        if (!start) begin
          arm <= 1'b1;
        end
      end else begin
        arm <= 1'b0;
      end

      case (state_q)
        ATTRACT: begin
          if (state_next == PLAY) begin
            lives <= LIVES_LOAD;
            score <= '0;
            level <= '0;
            blink <= 1'b1;
          end
        end
        PLAY: begin
          if (laser_shot) begin
            score <= score_add(score, SCORE_INC, SCORE_TOP);
          end
          if (ship_shot) begin
            lives <= (lives == '0) ? '0 : lives - 2'd1;
          end else if (wave_clear && (level < LEVEL_TOP)) begin
            level <= level + LEVEL_W'(1);
          end
        end
        RESPAWN: begin
          if (state_next == PLAY) begin
            blink <= 1'b1;
          end else if (blink_hit) begin
            blink <= ~blink;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: frame ticks are scoreboarded
// against the vsync falls that caused them; score results are queued as
// stimulus is applied and compared after the DUT updates.
module tb_game_sequencer;

  localparam int FRAME_CYC = 20;
  localparam int VS_LOW    = 4;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        vsync;
  logic        start;
  logic        ship_shot;
  logic        laser_shot;
  logic        wave_clear;
  logic        frame_tick;
  logic [2:0]  state;
  logic        play_en;
  logic        blink;
  logic [1:0]  lives;
  logic [13:0] score;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit run      = 1'b0;

  int          tick_q[$];
  logic [13:0] score_q[$];
  logic [13:0] exp_score = '0;
  logic [2:0]  exp_level = '0;
  logic [1:0]  exp_lives = '0;

  game_sequencer dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .vsync      (vsync),
    .start      (start),
    .ship_shot  (ship_shot),
    .laser_shot (laser_shot),
    .wave_clear (wave_clear),
    .frame_tick (frame_tick),
    .state      (state),
    .play_en    (play_en),
    .blink      (blink),
    .lives      (lives),
    .score      (score),
    .level      (level)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // vsync source: every falling edge books the cycle its tick is due.
  initial begin : vsync_gen
    int   phase;
    logic nv;
    vsync = 1'b1;
    phase = VS_LOW;
    forever begin
      @(posedge clk_100MHz);
      #1;
      if (run) begin
        phase = (phase + 1) % FRAME_CYC;
        nv = (phase >= VS_LOW);
        if (vsync && !nv) tick_q.push_back(cyc + 3);
        vsync = nv;
      end else begin
        vsync = 1'b1;
        phase = VS_LOW;
      end
    end
  end

  // Tick monitor: each frame_tick must match the oldest pending vsync fall.
  always @(negedge clk_100MHz) begin
    if (!reset && frame_tick) begin
      checks++;
      if (tick_q.size() == 0) begin
        failures++;
        $display("FAIL frame_tick_spurious cyc=%0d got tick, required none", cyc);
      end else begin
        int due;
        due = tick_q.pop_front();
        if (cyc !== due) begin
          failures++;
          $display("FAIL frame_tick_latency got cyc=%0d required cyc=%0d", cyc, due);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic wait_tick();
    int n = 0;
    @(negedge clk_100MHz);
    while (!frame_tick && n < 4 * FRAME_CYC) begin
      @(negedge clk_100MHz);
      n++;
    end
    if (!frame_tick) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout no frame_tick within %0d cycles", n);
    end
  endtask

  // One-cycle pulse on the hit inputs; the expected score is queued here.
  task automatic pulse(input logic s, input logic l, input logic w, input bit in_play);
    @(posedge clk_100MHz);
    #1;
    ship_shot = s; laser_shot = l; wave_clear = w;
    if (in_play && l) exp_score = (exp_score + 14'd10 > 14'd9999) ? 14'd9999 : exp_score + 14'd10;
    score_q.push_back(exp_score);
    @(posedge clk_100MHz);
    #1;
    ship_shot = 1'b0; laser_shot = 1'b0; wave_clear = 1'b0;
  endtask

  task automatic check_score(input string name);
    logic [13:0] e;
    e = score_q.pop_front();
    checks++;
    if (score !== e) begin
      failures++;
      $display("FAIL %s score got %0d required %0d", name, score, e);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (state !== 3'd0 || play_en !== 1'b0 || blink !== 1'b1 || lives !== 2'd0 ||
        score !== 14'd0 || level !== 3'd0 || frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL %s got st=%0d pe=%b bl=%b lv=%0d sc=%0d lvl=%0d ft=%b required 0/0/1/0/0/0/0",
               name, state, play_en, blink, lives, score, level, frame_tick);
    end
  endtask

  task automatic check_game_start(input string name);
    checks++;
    if (state !== 3'd1 || play_en !== 1'b1 || lives !== 2'd3 || score !== 14'd0 || level !== 3'd0) begin
      failures++;
      $display("FAIL %s got st=%0d pe=%b lv=%0d sc=%0d lvl=%0d required 1/1/3/0/0",
               name, state, play_en, lives, score, level);
    end
    exp_score = '0; exp_level = '0; exp_lives = 2'd3;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ship_shot = 1'b0; laser_shot = 1'b0; wave_clear = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    check_reset_values("reset_initial");
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL attract_idle state got %0d required 0", state);
    end
  endtask

  task automatic test_reset_mid_play();
    @(posedge clk_100MHz); #1 start = 1'b1;
    @(posedge clk_100MHz); #1;
    check_game_start("first_start");
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b1);
      check_score("score_step");
    end
    checks++;
    if (score !== 14'd40) begin
      failures++;
      $display("FAIL score_40 got %0d required 40", score);
    end
    @(negedge clk_100MHz); #1 reset = 1'b1;
    #1 check_reset_values("reset_async_mid_play");
    @(negedge clk_100MHz); reset = 1'b0;
    @(posedge clk_100MHz); #1 start = 1'b1;
    @(posedge clk_100MHz); #1;
    check_game_start("restart_after_reset");
  endtask

  task automatic test_respawn();
    run = 1'b1;
    wait_tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check_score("respawn_entry");
    exp_lives = 2'd2;
    checks++;
    if (state !== 3'd2 || lives !== 2'd2 || play_en !== 1'b0 || blink !== 1'b1) begin
      failures++;
      $display("FAIL respawn_entry got st=%0d lv=%0d pe=%b bl=%b required 2/2/0/1", state, lives, play_en, blink);
    end
    for (int k = 1; k <= 120; k++) begin
      wait_tick();
      @(negedge clk_100MHz);
      checks++;
      if (state !== 3'd2 || blink !== (((k / 8) % 2) == 0)) begin
        failures++;
        $display("FAIL respawn_blink tick=%0d got st=%0d bl=%b required 2/%b", k, state, blink, ((k / 8) % 2) == 0);
      end
      if (k == 40) begin
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        check_score("respawn_hits_ignored");
        checks++;
        if (state !== 3'd2 || lives !== 2'd2 || level !== 3'd0) begin
          failures++;
          $display("FAIL respawn_hits_ignored got st=%0d lv=%0d lvl=%0d required 2/2/0", state, lives, level);
        end
      end
    end
    @(negedge clk_100MHz);
    checks++;
    if (state !== 3'd1 || play_en !== 1'b1 || blink !== 1'b1 || lives !== 2'd2) begin
      failures++;
      $display("FAIL respawn_exit got st=%0d pe=%b bl=%b lv=%0d required 1/1/1/2", state, play_en, blink, lives);
    end
  endtask

  task automatic test_level_up();
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      pulse(1'b0, 1'b0, 1'b1, 1'b1);
      check_score("levelup_entry_score");
      if (exp_level != 3'd7) exp_level = exp_level + 3'd1;
      checks++;
      if (state !== 3'd3 || level !== exp_level || play_en !== 1'b0) begin
        failures++;
        $display("FAIL levelup_entry wave=%0d got st=%0d lvl=%0d pe=%b required 3/%0d/0", i, state, level, play_en, exp_level);
      end
      repeat (89) wait_tick();
      repeat (2) @(negedge clk_100MHz);
      checks++;
      if (state !== 3'd3) begin
        failures++;
        $display("FAIL levelup_hold wave=%0d state got %0d required 3", i, state);
      end
      wait_tick();
      repeat (2) @(negedge clk_100MHz);
      checks++;
      if (state !== 3'd1 || play_en !== 1'b1 || level !== exp_level) begin
        failures++;
        $display("FAIL levelup_exit wave=%0d got st=%0d pe=%b lvl=%0d required 1/1/%0d", i, state, play_en, level, exp_level);
      end
    end
  endtask

  task automatic test_simultaneous();
    wait_tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check_score("second_hit_score");
    checks++;
    if (state !== 3'd2 || lives !== 2'd1) begin
      failures++;
      $display("FAIL second_hit got st=%0d lv=%0d required 2/1", state, lives);
    end
    repeat (120) wait_tick();
    repeat (2) @(negedge clk_100MHz);
    wait_tick();
    pulse(1'b1, 1'b1, 1'b1, 1'b1);
    check_score("simultaneous_score");
    checks++;
    if (state !== 3'd4 || lives !== 2'd0 || level !== 3'd7 || play_en !== 1'b0) begin
      failures++;
      $display("FAIL simultaneous got st=%0d lv=%0d lvl=%0d pe=%b required 4/0/7/0", state, lives, level, play_en);
    end
  endtask

  task automatic test_game_over();
    repeat (179) wait_tick();
    repeat (2) @(negedge clk_100MHz);
    checks++;
    if (state !== 3'd4 || score !== exp_score || level !== 3'd7) begin
      failures++;
      $display("FAIL gameover_hold got st=%0d sc=%0d lvl=%0d required 4/%0d/7", state, score, level, exp_score);
    end
    wait_tick();
    repeat (2) @(negedge clk_100MHz);
    checks++;
    if (state !== 3'd0 || play_en !== 1'b0) begin
      failures++;
      $display("FAIL gameover_exit got st=%0d pe=%b required 0/0", state, play_en);
    end
    repeat (30) @(negedge clk_100MHz);
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL held_start_no_restart state got %0d required 0", state);
    end
    @(posedge clk_100MHz); #1 start = 1'b0;
    @(posedge clk_100MHz); #1 start = 1'b1;
    @(posedge clk_100MHz); #1;
    check_game_start("rearmed_start");
  endtask

  task automatic test_score_saturation();
    for (int i = 1; i <= 1001; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b1);
      check_score("score_sat_step");
      if (i == 999) begin
        checks++;
        if (score !== 14'd9990) begin
          failures++;
          $display("FAIL score_9990 got %0d required 9990", score);
        end
      end
    end
    checks++;
    if (score !== 14'd9999) begin
      failures++;
      $display("FAIL score_held_max got %0d required 9999", score);
    end
  endtask

  task automatic test_tick_drain();
    run = 1'b0;
    repeat (10) @(negedge clk_100MHz);
    checks++;
    if (tick_q.size() != 0) begin
      failures++;
      $display("FAIL tick_drain pending falls got %0d required 0", tick_q.size());
    end
  endtask

  initial begin : main
    test_reset();
    test_reset_mid_play();
    test_respawn();
    test_level_up();
    test_simultaneous();
    test_game_over();
    test_score_saturation();
    test_tick_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
